vga_mem_arbiter: RTL and testbench

VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

---
 rtl/vga_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_vga_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_arbiter.sv
// Single-port RAM arbiter: the VGA master always wins; the CPU is served by an IDLE/ISSUE/DATA FSM.
// Ports: i_vga_* read path (combinational to RAM, o_vga_dat is RAM data pass-through),
//        i_cpu_*/o_cpu_* request/ack handshake, o_ram_*/i_ram_dat RAM port, o_stall_cnt/o_conflict status.
module vga_mem_arbiter #(
    parameter logic [3:0] VGA_BASE = 4'h0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [11:0] i_vga_addr,
    input  logic        i_vga_cs,
    input  logic        i_vga_access,
    output logic [15:0] o_vga_dat,
    input  logic [15:0] i_cpu_addr,
    input  logic [15:0] i_cpu_dat,
    input  logic        i_cpu_cs,
    input  logic        i_cpu_we,
    output logic [15:0] o_cpu_dat,
    output logic        o_cpu_ack,
    output logic [15:0] o_ram_addr,
    output logic [15:0] o_ram_dat,
    output logic        o_ram_cs,
    output logic        o_ram_we,
    input  logic [15:0] i_ram_dat,
    output logic [15:0] o_stall_cnt,
    output logic        o_conflict
);

    typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] req_addr;
    logic [15:0] req_dat;
    logic        req_we;
    logic        cpu_start;
    logic        conflict_hit;
    logic        stall_inc;

    // VGA read data is the RAM output unchanged; the RAM already adds the one-cycle latency.
    assign o_vga_dat = i_ram_dat;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            o_cpu_ack   <= 1'b0;
            o_cpu_dat   <= 16'h0000;
            o_stall_cnt <= 16'h0000;
            o_conflict  <= 1'b0;
            req_addr    <= 16'h0000;
            req_dat     <= 16'h0000;
            req_we      <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_cpu_ack <= (state == DATA);
            if (state == DATA) begin
                o_cpu_dat <= req_we ? 16'h0000 : i_ram_dat;
            end
            if (cpu_start) begin
                req_addr <= i_cpu_addr;
                req_dat  <= i_cpu_dat;
                req_we   <= i_cpu_we;
            end
            if (conflict_hit) begin
                o_conflict <= 1'b1;
            end
            if (stall_inc && (o_stall_cnt != 16'hFFFF)) begin
                o_stall_cnt <= o_stall_cnt + 16'h0001;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        cpu_start    = 1'b0;
        conflict_hit = 1'b0;
        stall_inc    = 1'b0;
        o_ram_cs     = 1'b0;
        o_ram_we     = 1'b0;
        o_ram_addr   = 16'h0000;
        o_ram_dat    = 16'h0000;

        // VGA owns the RAM whenever it selects it, independent of FSM and reset.
        if (i_vga_cs) begin
            o_ram_cs   = 1'b1;
            o_ram_addr = {VGA_BASE, i_vga_addr};
        end

        case (state)
            IDLE: begin
                // While ack is high the CPU still holds cs for the finished request; ignore it.
                if (i_cpu_cs && !o_cpu_ack) begin
                    if (i_vga_access) begin
                        stall_inc = 1'b1;
                    end else begin
                        cpu_start = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (i_vga_cs) begin
                    // VGA skipped its access hint: it takes the RAM and the CPU request retries.
                    conflict_hit = 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    // A reset in this cycle aborts the access, so no write may reach the RAM.
                    if (!i_reset) begin
                        o_ram_cs   = 1'b1;
                        o_ram_we   = req_we;
                        o_ram_addr = req_addr;
                        o_ram_dat  = req_dat;
                    end
                    state_nxt = DATA;
                end
            end
            DATA: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: behavioural RAM, table-driven CPU/VGA vectors, a scoreboard for CPU
// read data, hand sequences for conflict and reset-in-ISSUE, and a random VGA/CPU mix.
module tb_vga_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] vga_addr;
    logic        vga_cs;
    logic        vga_access;
    logic [15:0] vga_rdat;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdat;
    logic        cpu_cs;
    logic        cpu_we;
    logic [15:0] cpu_rdat;
    logic        cpu_ack;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdat;
    logic        ram_cs;
    logic        ram_we;
    logic [15:0] ram_rdat;
    logic [15:0] stall_cnt;
    logic        conflict;

    always #5 clk = ~clk;

    vga_mem_arbiter #(.VGA_BASE(4'h1)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_vga_addr(vga_addr), .i_vga_cs(vga_cs), .i_vga_access(vga_access), .o_vga_dat(vga_rdat),
        .i_cpu_addr(cpu_addr), .i_cpu_dat(cpu_wdat), .i_cpu_cs(cpu_cs), .i_cpu_we(cpu_we),
        .o_cpu_dat(cpu_rdat), .o_cpu_ack(cpu_ack),
        .o_ram_addr(ram_addr), .o_ram_dat(ram_wdat), .o_ram_cs(ram_cs), .o_ram_we(ram_we),
        .i_ram_dat(ram_rdat), .o_stall_cnt(stall_cnt), .o_conflict(conflict)
    );

    // Synchronous single-port RAM, one-cycle read latency.
    bit [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= ram_wdat;
            else        ram_rdat      <= mem[ram_addr];
        end
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          req_cnt = 0;
    int          ack_cnt = 0;
    int          exp_stall = 0;
    logic [15:0] exp_q [$];
    logic [15:0] sb_exp;
    logic [15:0] shadow [int];
    bit          done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard and RAM-port protocol monitor, sampled 2 time units after the falling edge.
    always begin
        @(negedge clk);
        #2;
        if (cpu_ack) begin
            if (exp_q.size() == 0) begin
                check("ack_unexpected", 32'd1, 32'd0);
            end else begin
                sb_exp = exp_q.pop_front();
                check("cpu_rdat", {16'h0, cpu_rdat}, {16'h0, sb_exp});
                ack_cnt++;
            end
        end
        if (vga_cs) begin
            check("vga_no_write", {31'h0, ram_we}, 32'd0);
            check("vga_ram_addr", {16'h0, ram_addr}, {16'h0, 4'h1, vga_addr});
        end
    end

    // Called at a falling edge; returns at the falling edge where ack is seen.
    task automatic cpu_txn(input bit we, input logic [15:0] addr, input logic [15:0] dat,
                           input logic [15:0] exp_dat, input int hold, input bit chk, output int lat);
        bit got;
        got        = 1'b0;
        cpu_cs     = 1'b1;
        cpu_we     = we;
        cpu_addr   = addr;
        cpu_wdat   = dat;
        if (hold > 0) vga_access = 1'b1;
        exp_q.push_back(we ? 16'h0000 : exp_dat);
        req_cnt++;
        if (we) shadow[int'(addr)] = dat;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (cpu_ack) begin
                got = 1'b1;
                break;
            end
            if (chk && hold > 0 && lat <= hold) begin
                #1;
                check("no_ram_while_access", {31'h0, ram_cs}, 32'd0);
                if (lat == hold) vga_access = 1'b0;
            end
            if (chk && lat == hold + 1) begin
                #1;
                check("issue_ram_cs", {31'h0, ram_cs}, 32'd1);
                check("issue_ram_we", {31'h0, ram_we}, {31'h0, we});
                check("issue_ram_addr", {16'h0, ram_addr}, {16'h0, addr});
                if (we) check("issue_ram_dat", {16'h0, ram_wdat}, {16'h0, dat});
                // The request is latched; changing the bus now must not disturb it.
                cpu_addr = ~addr;
                cpu_wdat = ~dat;
            end
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        cpu_cs = 1'b0;
    endtask

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [15:0] dat;
        int          hold;
        logic [15:0] exp_dat;
        int          exp_lat;
    } txn_t;

    typedef struct {
        bit          rst;
        logic [11:0] addr;
        logic [15:0] exp_addr;
        logic [15:0] exp_dat;
    } vga_t;

    txn_t tbl [13];
    vga_t vtbl [4];

    initial begin
        int lat;
        bit got;
        tbl[0]  = '{1'b1, 16'h1234, 16'hBEEF, 0, 16'h0000, 3};
        tbl[1]  = '{1'b0, 16'h1234, 16'h0000, 0, 16'hBEEF, 3};
        tbl[2]  = '{1'b1, 16'h0000, 16'h0001, 0, 16'h0000, 3};
        tbl[3]  = '{1'b1, 16'hFFFF, 16'hA5A5, 0, 16'h0000, 3};
        tbl[4]  = '{1'b0, 16'hFFFF, 16'h0000, 0, 16'hA5A5, 3};
        tbl[5]  = '{1'b0, 16'h0000, 16'h0000, 0, 16'h0001, 3};
        tbl[6]  = '{1'b0, 16'h4321, 16'h0000, 0, 16'h0000, 3};
        tbl[7]  = '{1'b0, 16'h1234, 16'h0000, 5, 16'hBEEF, 8};
        tbl[8]  = '{1'b1, 16'h1234, 16'h0F0F, 2, 16'h0000, 5};
        tbl[9]  = '{1'b0, 16'h1234, 16'h0000, 0, 16'h0F0F, 3};
        tbl[10] = '{1'b1, 16'h10A5, 16'hCAFE, 0, 16'h0000, 3};
        tbl[11] = '{1'b1, 16'h1000, 16'h1111, 0, 16'h0000, 3};
        tbl[12] = '{1'b1, 16'h1FFF, 16'h2222, 0, 16'h0000, 3};
        vtbl[0] = '{1'b0, 12'h0A5, 16'h10A5, 16'hCAFE};
        vtbl[1] = '{1'b0, 12'h000, 16'h1000, 16'h1111};
        vtbl[2] = '{1'b1, 12'hFFF, 16'h1FFF, 16'h2222};
        vtbl[3] = '{1'b0, 12'h123, 16'h1123, 16'h0000};

        rst = 1'b1; vga_addr = 12'h0; vga_cs = 1'b0; vga_access = 1'b0;
        cpu_addr = 16'h0; cpu_wdat = 16'h0; cpu_cs = 1'b0; cpu_we = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", {31'h0, cpu_ack}, 32'd0);
        check("rst_cpu_dat", {16'h0, cpu_rdat}, 32'd0);
        check("rst_stall", {16'h0, stall_cnt}, 32'd0);
        check("rst_conflict", {31'h0, conflict}, 32'd0);
        check("rst_ram_cs", {31'h0, ram_cs}, 32'd0);
        check("rst_ram_addr", {16'h0, ram_addr}, 32'd0);
        rst = 1'b0;

        // CPU transactions, each started from a quiet IDLE cycle.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            cpu_txn(tbl[i].we, tbl[i].addr, tbl[i].dat, tbl[i].exp_dat, tbl[i].hold, 1'b1, lat);
            check($sformatf("lat[%0d]", i), lat, tbl[i].exp_lat);
            exp_stall += tbl[i].hold;
            check($sformatf("stall[%0d]", i), {16'h0, stall_cnt}, exp_stall);
        end

        // VGA reads: combinational address path, data one cycle later, reset does not gate it.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst      = vtbl[i].rst;
            vga_cs   = 1'b1;
            vga_addr = vtbl[i].addr;
            #1;
            check($sformatf("vga_ram_cs[%0d]", i), {31'h0, ram_cs}, 32'd1);
            check($sformatf("vga_ram_we[%0d]", i), {31'h0, ram_we}, 32'd0);
            check($sformatf("vga_addr[%0d]", i), {16'h0, ram_addr}, {16'h0, vtbl[i].exp_addr});
            @(negedge clk);
            check($sformatf("vga_dat[%0d]", i), {16'h0, vga_rdat}, {16'h0, vtbl[i].exp_dat});
            vga_cs = 1'b0;
            if (vtbl[i].rst) exp_stall = 0;
            rst = 1'b0;
        end
        check("stall_after_vga_rst", {16'h0, stall_cnt}, exp_stall);

        // VGA selects the RAM in ISSUE without an access hint.
        @(negedge clk);
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        exp_q.push_back(16'h0F0F); req_cnt++;
        @(negedge clk);
        vga_cs = 1'b1; vga_addr = 12'h0A5;
        #1;
        check("cf_ram_addr", {16'h0, ram_addr}, 32'h10A5);
        check("cf_ram_we", {31'h0, ram_we}, 32'd0);
        @(negedge clk);
        check("cf_flag", {31'h0, conflict}, 32'd1);
        check("cf_vga_dat", {16'h0, vga_rdat}, 32'hCAFE);
        vga_cs = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                got = 1'b1;
                break;
            end
        end
        check("cf_retry_ack", {31'h0, got}, 32'd1);
        cpu_cs = 1'b0;
        check("cf_sticky", {31'h0, conflict}, 32'd1);

        // Reset while a write is in ISSUE: no ack, everything back to reset values.
        @(negedge clk);
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2AAA; cpu_wdat = 16'h5555;
        @(negedge clk);
        check("ri_issue_we", {31'h0, ram_we}, 32'd1);
        rst = 1'b1; cpu_cs = 1'b0;
        @(negedge clk);
        check("ri_ack", {31'h0, cpu_ack}, 32'd0);
        check("ri_cpu_dat", {16'h0, cpu_rdat}, 32'd0);
        check("ri_stall", {16'h0, stall_cnt}, 32'd0);
        check("ri_conflict", {31'h0, conflict}, 32'd0);
        check("ri_ram_cs", {31'h0, ram_cs}, 32'd0);
        check("ri_ram_we", {31'h0, ram_we}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Random VGA fetch phases, access signalled one cycle ahead of each 4-cycle burst, plus back-to-back CPU traffic.
        fork
            begin
                bit fetch_cur;
                bit fetch_next;
                int pos;
                fetch_cur = 1'b0;
                fetch_next = 1'b0;
                for (int c = 0; c < 10000; c++) begin
                    @(negedge clk);
                    pos = c % 8;
                    if (pos == 0) fetch_cur = fetch_next;
                    if (pos == 6) fetch_next = ($urandom_range(3) != 0);
                    vga_access = (pos == 7 && fetch_next) || (pos <= 2 && fetch_cur);
                    vga_cs     = (pos <= 3) && fetch_cur;
                    vga_addr   = 12'($urandom_range(4095));
                end
                @(negedge clk);
                vga_cs = 1'b0;
                vga_access = 1'b0;
                done = 1'b1;
            end
            begin
                bit          r_we;
                logic [15:0] r_addr;
                logic [15:0] r_dat;
                logic [15:0] r_exp;
                int          r_lat;
                @(negedge clk);
                while (!done) begin
                    r_we   = 1'($urandom_range(1));
                    r_addr = 16'($urandom_range(255));
                    r_dat  = 16'($urandom);
                    r_exp  = shadow.exists(int'(r_addr)) ? shadow[int'(r_addr)] : 16'h0000;
                    cpu_txn(r_we, r_addr, r_dat, r_exp, 0, 1'b0, r_lat);
                    check("rand_lat_min", {31'h0, (r_lat >= 3)}, 32'd1);
                end
            end
        join

        repeat (4) @(negedge clk);
        check("rand_conflict", {31'h0, conflict}, 32'd0);
        check("ack_count", ack_cnt, req_cnt);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
